// File: rtl/trfir_ctrl.sv
// trfir_ctrl: sequencing controller for a transposed-form FIR tap chain.
// Loads the weight vector, streams one activation row and forwards only fully-formed results.
module trfir_ctrl #(
  parameter int nb_taps      = 5,
  parameter int weight_width = 16,
  parameter int act_width    = 16,
  parameter int DReg_width   = 24,
  parameter int len_width    = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             reload_w,
  input  logic [len_width-1:0]             row_len,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [weight_width-1:0]          w_data,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [act_width-1:0]             a_data,
  output logic [weight_width*nb_taps-1:0]  WRegs,
  output logic [act_width-1:0]             act,
  output logic                             DFF_en,
  input  logic [DReg_width-1:0]            fir_out,
  output logic                             y_valid,
  input  logic                             y_ready,
  output logic [DReg_width-1:0]            y_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_W = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  localparam int                   CNT_W  = (nb_taps > 1) ? $clog2(nb_taps) : 1;
  localparam logic [len_width-1:0] TAPS   = len_width'(nb_taps);
  localparam logic [len_width-1:0] WARMUP = len_width'(nb_taps - 1);
  localparam logic [CNT_W-1:0]     LAST_W = CNT_W'(nb_taps - 1);

  logic [1:0]           state;
  logic [len_width-1:0] row_len_q;
  logic [len_width-1:0] in_cnt;
  logic [len_width-1:0] in_cnt_inc;
  logic [CNT_W-1:0]     w_cnt;
  logic                 w_acc;
  logic                 short_row;
  logic                 drain_exit;

  // Backpressure stalls the chain so fir_out cannot move under a pending result.
  assign busy       = (state != IDLE);
  assign w_ready    = (state == LOAD_W);
  assign a_ready    = (state == STREAM) && (!y_valid || y_ready);
  assign DFF_en     = a_valid && a_ready;
  assign w_acc      = w_valid && w_ready;
  assign act        = a_data;
  assign y_data     = fir_out;
  assign in_cnt_inc = in_cnt + 1'b1;
  assign short_row  = (row_len < TAPS);
  assign drain_exit = (state == DRAIN) && (!y_valid || y_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_len_q <= '0;
      in_cnt    <= '0;
      w_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !short_row) begin
            row_len_q <= row_len;
            in_cnt    <= '0;
            w_cnt     <= '0;
            state     <= reload_w ? LOAD_W : STREAM;
          end
        end
        LOAD_W: begin
          if (w_acc) begin
            if (w_cnt == LAST_W) state <= STREAM;
            else                 w_cnt <= w_cnt + 1'b1;
          end
        end
        STREAM: begin
          if (DFF_en) begin
            in_cnt <= in_cnt_inc;
            if (in_cnt_inc == row_len_q) state <= DRAIN;
          end
        end
        default: begin
          if (drain_exit) state <= IDLE;
        end
      endcase
    end
  end

  // Weights persist across rows; only a LOAD_W accept rewrites a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WRegs <= '0;
    end else if (w_acc) begin
      for (int k = 0; k < nb_taps; k++) begin
        if (w_cnt == CNT_W'(k)) WRegs[k*weight_width +: weight_width] <= w_data;
      end
    end
  end

  // The first nb_taps-1 accepts of a row only prime the chain and produce no result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (DFF_en && (in_cnt >= WARMUP)) y_valid <= 1'b1;
      else if (y_ready)                 y_valid <= 1'b0;
      done <= drain_exit;
      err  <= (state == IDLE) && start && short_row;
    end
  end

endmodule

// File: tb/tb_trfir_ctrl.sv
// tb_trfir_ctrl: randomized self-checking bench for trfir_ctrl, with a behavioural FIR
// datapath stub and a sliding-window dot-product reference for the expected results.
`timescale 1ns/1ps
module tb_trfir_ctrl;
  localparam int NT = 5;
  localparam int WW = 16;
  localparam int AW = 16;
  localparam int DW = 24;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          reload_w = 1'b0;
  logic [LW-1:0] row_len = '0;
  logic          busy, done, err;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [WW-1:0] w_data = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [AW-1:0] a_data = '0;
  logic [WW*NT-1:0] WRegs;
  logic [AW-1:0] act;
  logic          DFF_en;
  logic [DW-1:0] fir_out;
  logic          y_valid;
  logic          y_ready = 1'b1;
  logic [DW-1:0] y_data;

  int n_compared = 0;
  int n_mismatched = 0;

  int wvec [NT];
  int avec [$];

  always #5 clk = ~clk;

  trfir_ctrl #(.nb_taps(NT), .weight_width(WW), .act_width(AW), .DReg_width(DW), .len_width(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reload_w(reload_w), .row_len(row_len),
    .busy(busy), .done(done), .err(err),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .WRegs(WRegs), .act(act), .DFF_en(DFF_en), .fir_out(fir_out),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data)
  );

  // Output-equivalent FIR stub: the registered output is the dot product of the
  // current weights with the last NT enabled activations (slot 0 = oldest).
  logic [AW-1:0] win [NT];
  logic [AW-1:0] win_next [NT];
  logic [DW-1:0] fir_next;
  always_comb begin
    for (int j = 0; j < NT-1; j++) win_next[j] = win[j+1];
    win_next[NT-1] = act;
    fir_next = '0;
    for (int j = 0; j < NT; j++)
      fir_next = fir_next + DW'({16'd0, WRegs[j*WW +: WW]} * {16'd0, win_next[j]});
  end
  always @(posedge clk) begin
    if (DFF_en) begin
      win     <= win_next;
      fir_out <= fir_next;
    end
  end

  int done_cnt = 0, err_cnt = 0, w_ready_cnt = 0, stall_cnt = 0, stall_viol = 0, hold_viol = 0;
  logic [DW-1:0] got [$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_y = '0;
  always @(negedge clk) begin
    if (y_valid && y_ready) got.push_back(y_data);
    if (done)    done_cnt    <= done_cnt + 1;
    if (err)     err_cnt     <= err_cnt + 1;
    if (w_ready) w_ready_cnt <= w_ready_cnt + 1;
    if (y_valid && !y_ready) begin
      stall_cnt <= stall_cnt + 1;
      if (a_ready || DFF_en) stall_viol <= stall_viol + 1;
    end
    if (prev_stall && (!y_valid || y_data !== prev_y)) hold_viol <= hold_viol + 1;
    prev_stall <= y_valid && !y_ready && rst_n;
    prev_y     <= y_data;
  end

  function automatic logic [DW-1:0] exp_y(input int n);
    logic [DW-1:0] s = '0;
    for (int j = 0; j < NT; j++) s = s + DW'(wvec[j] * avec[n-NT+1+j]);
    return s;
  endfunction

  function automatic logic [WW*NT-1:0] pack_w();
    logic [WW*NT-1:0] p = '0;
    for (int k = 0; k < NT; k++) p[k*WW +: WW] = WW'(wvec[k]);
    return p;
  endfunction

  // Drives one row: start pulse, then weights/activations with random gaps until done.
  task automatic run_row(input bit reload, input int len, input int gap_pct, input int yr_pct,
                         input int bp, input int busy_start_at, input int abort_after,
                         output int cycles, output bit timed_out,
                         output logic t1_busy, output logic t1_w_ready, output logic t1_a_ready);
    int wi = 0, ai = 0, bp_left = 0, done0;
    bit bp_armed;
    got.delete();
    @(posedge clk); #1;
    start = 1'b1; reload_w = reload; row_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0; reload_w = 1'b0;
    t1_busy = busy; t1_w_ready = w_ready; t1_a_ready = a_ready;
    done0 = done_cnt; cycles = 0; timed_out = 1'b0; bp_armed = (bp > 0);
    while (done_cnt == done0 && !timed_out && !(abort_after >= 0 && ai >= abort_after)) begin
      start = (cycles == busy_start_at);
      if (start) begin row_len = LW'(2); reload_w = 1'b1; end
      else reload_w = 1'b0;
      w_valid = (wi < NT) && ($urandom_range(99) >= gap_pct);
      w_data  = w_valid ? WW'(wvec[wi]) : WW'($urandom);
      a_valid = (ai < len) && ($urandom_range(99) >= gap_pct);
      a_data  = a_valid ? AW'(avec[ai]) : AW'($urandom);
      if (bp_armed && y_valid) begin bp_left = bp; bp_armed = 1'b0; end
      if (bp_left > 0) begin y_ready = 1'b0; bp_left--; end
      else y_ready = ($urandom_range(99) < yr_pct);
      @(negedge clk);
      if (w_valid && w_ready) wi++;
      if (a_valid && a_ready) ai++;
      @(posedge clk); #1;
      cycles++;
      if (cycles > 3000) timed_out = 1'b1;
    end
    start = 1'b0; reload_w = 1'b0; w_valid = 1'b0; a_valid = 1'b0; y_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a_valid = 1'b1; w_valid = 1'b1;
    #3;
    n_compared++;
    if ({busy, done, err, y_valid, w_ready, a_ready, DFF_en} !== 7'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset.outputs: got %b expected 0000000",
               {busy, done, err, y_valid, w_ready, a_ready, DFF_en});
    end
    n_compared++;
    if (WRegs !== '0) begin n_mismatched++; $display("[TB] FAIL reset.wregs: got %h expected 0", WRegs); end
    start = 1'b0; a_valid = 1'b0; w_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    n_compared++;
    if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset.idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_row();
    int lit [4] = '{55, 70, 85, 100};
    int cyc, d0; bit to; logic b1, wr1, ar1;
    for (int k = 0; k < NT; k++) wvec[k] = k + 1;
    avec.delete(); for (int i = 1; i <= 8; i++) avec.push_back(i);
    d0 = done_cnt;
    run_row(1'b1, 8, 0, 100, 0, -1, -1, cyc, to, b1, wr1, ar1);
    repeat (2) @(posedge clk); #1;
    n_compared++; if (to) begin n_mismatched++; $display("[TB] FAIL full_row.timeout: got 1 expected 0"); end
    n_compared++;
    if ({b1, wr1, ar1} !== 3'b110) begin n_mismatched++; $display("[TB] FAIL full_row.start_latency: got %b expected 110", {b1, wr1, ar1}); end
    n_compared++; if (got.size() !== 4) begin n_mismatched++; $display("[TB] FAIL full_row.count: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (got[i] !== DW'(lit[i])) begin n_mismatched++; $display("[TB] FAIL full_row.y%0d: got %0d expected %0d", i, got[i], lit[i]); end
    end
    n_compared++; if (WRegs !== pack_w()) begin n_mismatched++; $display("[TB] FAIL full_row.wregs: got %h expected %h", WRegs, pack_w()); end
    n_compared++; if (cyc !== NT + 8 + 2) begin n_mismatched++; $display("[TB] FAIL full_row.cycles: got %0d expected %0d", cyc, NT + 10); end
    n_compared++; if (done_cnt - d0 !== 1) begin n_mismatched++; $display("[TB] FAIL full_row.done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    int lit [4] = '{55, 70, 85, 100};
    int cyc, s0, v0, h0; bit to; logic b1, wr1, ar1;
    s0 = stall_cnt; v0 = stall_viol; h0 = hold_viol;
    run_row(1'b1, 8, 0, 100, 3, -1, -1, cyc, to, b1, wr1, ar1);
    @(posedge clk); #1;
    n_compared++; if (to) begin n_mismatched++; $display("[TB] FAIL backpressure.timeout: got 1 expected 0"); end
    n_compared++; if (stall_cnt - s0 !== 3) begin n_mismatched++; $display("[TB] FAIL backpressure.stall_cycles: got %0d expected 3", stall_cnt - s0); end
    n_compared++; if (stall_viol - v0 !== 0) begin n_mismatched++; $display("[TB] FAIL backpressure.chain_frozen: got %0d violations expected 0", stall_viol - v0); end
    n_compared++; if (hold_viol - h0 !== 0) begin n_mismatched++; $display("[TB] FAIL backpressure.y_hold: got %0d violations expected 0", hold_viol - h0); end
    n_compared++; if (got.size() !== 4) begin n_mismatched++; $display("[TB] FAIL backpressure.count: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (got[i] !== DW'(lit[i])) begin n_mismatched++; $display("[TB] FAIL backpressure.y%0d: got %0d expected %0d", i, got[i], lit[i]); end
    end
  endtask

  task automatic test_no_reload();
    int lit [4] = '{70, 85, 100, 115};
    int cyc, w0; bit to; logic b1, wr1, ar1;
    avec.delete(); for (int i = 2; i <= 9; i++) avec.push_back(i);
    w0 = w_ready_cnt;
    run_row(1'b0, 8, 0, 100, 0, -1, -1, cyc, to, b1, wr1, ar1);
    @(posedge clk); #1;
    n_compared++; if (to) begin n_mismatched++; $display("[TB] FAIL no_reload.timeout: got 1 expected 0"); end
    n_compared++;
    if ({b1, wr1, ar1} !== 3'b101) begin n_mismatched++; $display("[TB] FAIL no_reload.start_latency: got %b expected 101", {b1, wr1, ar1}); end
    n_compared++; if (w_ready_cnt - w0 !== 0) begin n_mismatched++; $display("[TB] FAIL no_reload.w_ready_cycles: got %0d expected 0", w_ready_cnt - w0); end
    n_compared++; if (WRegs !== pack_w()) begin n_mismatched++; $display("[TB] FAIL no_reload.wregs: got %h expected %h", WRegs, pack_w()); end
    n_compared++; if (got.size() !== 4) begin n_mismatched++; $display("[TB] FAIL no_reload.count: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (got[i] !== DW'(lit[i])) begin n_mismatched++; $display("[TB] FAIL no_reload.y%0d: got %0d expected %0d", i, got[i], lit[i]); end
    end
    n_compared++; if (cyc !== 8 + 2) begin n_mismatched++; $display("[TB] FAIL no_reload.cycles: got %0d expected 10", cyc); end
  endtask

  task automatic test_short_row();
    int lens [2] = '{NT - 1, 0};
    foreach (lens[i]) begin
      @(posedge clk); #1;
      start = 1'b1; reload_w = 1'b1; row_len = LW'(lens[i]);
      @(posedge clk); #1;
      start = 1'b0; reload_w = 1'b0;
      n_compared++;
      if ({err, busy, w_ready, a_ready} !== 4'b1000) begin
        n_mismatched++; $display("[TB] FAIL short_row.len%0d_t1: got %b expected 1000", lens[i], {err, busy, w_ready, a_ready});
      end
      @(posedge clk); #1;
      n_compared++;
      if ({err, busy, w_ready, a_ready} !== 4'b0000) begin
        n_mismatched++; $display("[TB] FAIL short_row.len%0d_t2: got %b expected 0000", lens[i], {err, busy, w_ready, a_ready});
      end
    end
  endtask

  task automatic test_start_busy();
    int cyc, e0, d0; bit to; logic b1, wr1, ar1;
    for (int k = 0; k < NT; k++) wvec[k] = $urandom_range(255);
    avec.delete(); for (int i = 0; i < 9; i++) avec.push_back($urandom_range(255));
    e0 = err_cnt; d0 = done_cnt;
    run_row(1'b1, 9, 0, 100, 0, NT + 3, -1, cyc, to, b1, wr1, ar1);
    repeat (2) @(posedge clk); #1;
    n_compared++; if (to) begin n_mismatched++; $display("[TB] FAIL start_busy.timeout: got 1 expected 0"); end
    n_compared++; if (err_cnt - e0 !== 0) begin n_mismatched++; $display("[TB] FAIL start_busy.err: got %0d expected 0", err_cnt - e0); end
    n_compared++; if (done_cnt - d0 !== 1) begin n_mismatched++; $display("[TB] FAIL start_busy.done_pulses: got %0d expected 1", done_cnt - d0); end
    n_compared++; if (WRegs !== pack_w()) begin n_mismatched++; $display("[TB] FAIL start_busy.wregs: got %h expected %h", WRegs, pack_w()); end
    n_compared++; if (got.size() !== 9 - NT + 1) begin n_mismatched++; $display("[TB] FAIL start_busy.count: got %0d expected %0d", got.size(), 9 - NT + 1); end
    for (int n = NT - 1; n < 9; n++) begin
      n_compared++;
      if (got[n-NT+1] !== exp_y(n)) begin n_mismatched++; $display("[TB] FAIL start_busy.y%0d: got %0d expected %0d", n-NT+1, got[n-NT+1], exp_y(n)); end
    end
  endtask

  task automatic test_reset_mid_row();
    int lit [4] = '{55, 70, 85, 100};
    int cyc, d0; bit to; logic b1, wr1, ar1;
    for (int k = 0; k < NT; k++) wvec[k] = NT - k;
    avec.delete(); for (int i = 0; i < 8; i++) avec.push_back(9 - i);
    d0 = done_cnt;
    run_row(1'b1, 8, 0, 100, 0, -1, 3, cyc, to, b1, wr1, ar1);
    a_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if ({busy, done, err, y_valid, w_ready, a_ready, DFF_en} !== 7'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mid.outputs: got %b expected 0000000", {busy, done, err, y_valid, w_ready, a_ready, DFF_en});
    end
    n_compared++;
    if (WRegs !== '0) begin n_mismatched++; $display("[TB] FAIL reset_mid.wregs: got %h expected 0", WRegs); end
    a_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_compared++; if (done_cnt - d0 !== 0) begin n_mismatched++; $display("[TB] FAIL reset_mid.no_done: got %0d expected 0", done_cnt - d0); end
    for (int k = 0; k < NT; k++) wvec[k] = k + 1;
    avec.delete(); for (int i = 1; i <= 8; i++) avec.push_back(i);
    run_row(1'b1, 8, 0, 100, 0, -1, -1, cyc, to, b1, wr1, ar1);
    n_compared++; if (to) begin n_mismatched++; $display("[TB] FAIL reset_mid.timeout: got 1 expected 0"); end
    n_compared++; if (got.size() !== 4) begin n_mismatched++; $display("[TB] FAIL reset_mid.count: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (got[i] !== DW'(lit[i])) begin n_mismatched++; $display("[TB] FAIL reset_mid.y%0d: got %0d expected %0d", i, got[i], lit[i]); end
    end
  endtask

  task automatic test_random_rows();
    int cyc, len, e0; bit to, reload; logic b1, wr1, ar1;
    for (int r = 0; r < 12; r++) begin
      reload = (r == 0) || ($urandom_range(1) == 1);
      if (reload) for (int k = 0; k < NT; k++) wvec[k] = $urandom_range(255);
      len = $urandom_range(NT + 8, NT);
      avec.delete(); for (int i = 0; i < len; i++) avec.push_back($urandom_range(255));
      e0 = err_cnt;
      run_row(reload, len, 30, 70, 0, -1, -1, cyc, to, b1, wr1, ar1);
      n_compared++; if (to) begin n_mismatched++; $display("[TB] FAIL random.r%0d_timeout: got 1 expected 0", r); end
      n_compared++; if (err_cnt - e0 !== 0) begin n_mismatched++; $display("[TB] FAIL random.r%0d_err: got %0d expected 0", r, err_cnt - e0); end
      n_compared++; if (WRegs !== pack_w()) begin n_mismatched++; $display("[TB] FAIL random.r%0d_wregs: got %h expected %h", r, WRegs, pack_w()); end
      n_compared++;
      if (got.size() !== len - NT + 1) begin n_mismatched++; $display("[TB] FAIL random.r%0d_count: got %0d expected %0d", r, got.size(), len - NT + 1); end
      for (int n = NT - 1; n < len; n++) begin
        n_compared++;
        if (got[n-NT+1] !== exp_y(n)) begin n_mismatched++; $display("[TB] FAIL random.r%0d_y%0d: got %0d expected %0d", r, n-NT+1, got[n-NT+1], exp_y(n)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_backpressure();
    test_no_reload();
    test_short_row();
    test_start_busy();
    test_reset_mid_row();
    test_random_rows();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
